// File: rtl/led_pwm_driver_if.sv
// led_pwm_driver_if
// Configuration bus between a bus master and the LED PWM driver.
//   we     : write strobe, a write lands on the clock edge where it is high
//   addr   : register select (0 = CTRL, 1 = PRESCALE, 2 = BLINKMASK, 3 = unused)
//   byteen : per-byte write enable, bit i qualifies wd[8i+7:8i]
//   wd     : write data
//   rd     : combinational read data of the register selected by addr
interface led_pwm_driver_if;
  logic        we;
  logic [1:0]  addr;
  logic [3:0]  byteen;
  logic [31:0] wd;
  logic [31:0] rd;

  modport master (output we, output addr, output byteen, output wd, input rd);
  modport slave  (input we, input addr, input byteen, input wd, output rd);
endinterface

// File: rtl/led_pwm_driver.sv
// led_pwm_driver
// Dims and blinks a 32-bit LED pattern before it reaches the board pins.
// A prescaler produces ticks, ticks advance an 8-bit PWM counter compared
// against a duty value, and every 16 PWM periods a blink state toggles so
// that LEDs selected in BLINKMASK switch off for alternate phases.
//   clk      : system clock, all state changes on its rising edge
//   reset    : synchronous, active-high
//   bus      : configuration register bus (slave side)
//   light_in : active-high LED pattern from the upstream LED register
//   led_n    : registered, active-low drive to the LED pins
module led_pwm_driver (
  input  logic                    clk,
  input  logic                    reset,
  led_pwm_driver_if.slave         bus,
  input  logic [31:0]             light_in,
  output logic [31:0]             led_n
);

  typedef enum logic {
    BLINK_ON  = 1'b0,
    BLINK_OFF = 1'b1
  } blinkState_e;

  logic        enable_q, enable_d;
  logic        blinkEn_q, blinkEn_d;
  logic [7:0]  duty_q, duty_d;
  logic [15:0] prescale_q, prescale_d;
  logic [31:0] blinkMask_q, blinkMask_d;
  logic [15:0] presCnt_q, presCnt_d;
  logic [7:0]  pwmCnt_q, pwmCnt_d;
  logic [3:0]  blinkDiv_q, blinkDiv_d;
  blinkState_e state_q, state_d;
  logic [31:0] ledN_q, ledN_d;

  logic        prescaleWrite;
  logic        tick;
  logic        wrap;
  logic        pwmOn;
  logic        blinkOff;

  // Register writes: only bytes with their enable set are merged, and only
  // the implemented bits of each register are ever stored. prescaleWrite
  // flags a write that touches the stored PRESCALE bytes so the prescaler
  // count can be reloaded with the fresh value on the same edge.
  always_comb begin
    enable_d      = enable_q;
    blinkEn_d     = blinkEn_q;
    duty_d        = duty_q;
    prescale_d    = prescale_q;
    blinkMask_d   = blinkMask_q;
    prescaleWrite = 1'b0;
    if (bus.we) begin
      case (bus.addr)
        2'd0: begin
          if (bus.byteen[0]) begin
            enable_d  = bus.wd[0];
            blinkEn_d = bus.wd[1];
          end
          if (bus.byteen[1]) begin
            duty_d = bus.wd[15:8];
          end
        end
        2'd1: begin
          if (bus.byteen[0]) begin
            prescale_d[7:0] = bus.wd[7:0];
          end
          if (bus.byteen[1]) begin
            prescale_d[15:8] = bus.wd[15:8];
          end
          prescaleWrite = |bus.byteen[1:0];
        end
        2'd2: begin
          for (int i = 0; i < 4; i++) begin
            if (bus.byteen[i]) begin
              blinkMask_d[8*i +: 8] = bus.wd[8*i +: 8];
            end
          end
        end
        default: begin
        end
      endcase
    end
  end

  // Timing chain. All decisions use the current register values, so a write
  // landing together with a tick only matters from the next cycle on; the one
  // exception is a PRESCALE write, which reloads the count immediately.
  // While disabled everything is pinned to its reset value so that enabling
  // restarts the pattern from a known phase.
  always_comb begin
    tick       = enable_q && (presCnt_q == 16'd0);
    wrap       = tick && (pwmCnt_q == 8'hFF);
    presCnt_d  = presCnt_q;
    pwmCnt_d   = pwmCnt_q;
    blinkDiv_d = blinkDiv_q;
    state_d    = state_q;
    if (!enable_q) begin
      presCnt_d  = 16'd0;
      pwmCnt_d   = 8'd0;
      blinkDiv_d = 4'd0;
      state_d    = BLINK_ON;
    end else begin
      if (prescaleWrite) begin
        presCnt_d = prescale_d;
      end else if (tick) begin
        presCnt_d = prescale_q;
      end else begin
        presCnt_d = presCnt_q - 16'd1;
      end
      if (tick) begin
        pwmCnt_d = pwmCnt_q + 8'd1;
      end
      if (wrap) begin
        blinkDiv_d = blinkDiv_q + 4'd1;
        if (blinkDiv_q == 4'hF) begin
          state_d = (state_q == BLINK_ON) ? BLINK_OFF : BLINK_ON;
        end
      end
    end
  end

  // Output gating. Full duty bypasses the compare so 0xFF means always on,
  // and the blink state keeps running even when blinking is not enabled.
  always_comb begin
    pwmOn    = (duty_q == 8'hFF) || (pwmCnt_q < duty_q);
    blinkOff = blinkEn_q && (state_q == BLINK_OFF);
    ledN_d   = ~(light_in & {32{enable_q & pwmOn}} & ~(blinkMask_q & {32{blinkOff}}));
  end

  // All state, including the blink state machine and the output register.
  // Reset wins over any write presented on the same edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      enable_q    <= 1'b1;
      blinkEn_q   <= 1'b0;
      duty_q      <= 8'hFF;
      prescale_q  <= 16'd0;
      blinkMask_q <= 32'd0;
      presCnt_q   <= 16'd0;
      pwmCnt_q    <= 8'd0;
      blinkDiv_q  <= 4'd0;
      state_q     <= BLINK_ON;
      ledN_q      <= 32'hFFFF_FFFF;
    end else begin
      enable_q    <= enable_d;
      blinkEn_q   <= blinkEn_d;
      duty_q      <= duty_d;
      prescale_q  <= prescale_d;
      blinkMask_q <= blinkMask_d;
      presCnt_q   <= presCnt_d;
      pwmCnt_q    <= pwmCnt_d;
      blinkDiv_q  <= blinkDiv_d;
      state_q     <= state_d;
      ledN_q      <= ledN_d;
    end
  end

  // Read mux; unimplemented bits and the unused address read as zero.
  always_comb begin
    case (bus.addr)
      2'd0:    bus.rd = {16'd0, duty_q, 6'd0, blinkEn_q, enable_q};
      2'd1:    bus.rd = {16'd0, prescale_q};
      2'd2:    bus.rd = blinkMask_q;
      default: bus.rd = 32'd0;
    endcase
  end

  assign led_n = ledN_q;

endmodule

// File: tb/tb_led_pwm_driver.sv
// tb_led_pwm_driver
// Self-checking bench for led_pwm_driver: a table of single-cycle register
// and pass-through vectors, followed by multi-cycle sequences for PWM duty,
// prescaling, blinking, disable/re-enable and reset during a write.
module tb_led_pwm_driver;

  typedef struct {
    logic        we;
    logic [1:0]  addr;
    logic [3:0]  byteen;
    logic [31:0] wd;
    logic [31:0] light;
    logic [31:0] expRd;
    logic [31:0] expLedN;
  } vec_t;

  logic        clk;
  logic        reset;
  logic [31:0] lightIn;
  logic [31:0] ledN;
  int          checks;
  int          errors;
  vec_t        vecs [14];

  led_pwm_driver_if busIf ();

  led_pwm_driver dut (
    .clk      (clk),
    .reset    (reset),
    .bus      (busIf),
    .light_in (lightIn),
    .led_n    (ledN)
  );

  // Free-running clock, 10 time units per period.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Hard stop in case a sequence stalls.
  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input vec_t v, input int idx);
    @(negedge clk);
    busIf.we     = v.we;
    busIf.addr   = v.addr;
    busIf.byteen = v.byteen;
    busIf.wd     = v.wd;
    lightIn      = v.light;
    @(posedge clk);
    #1;
    checkOutput($sformatf("vec%0d_rd", idx), busIf.rd, v.expRd);
    checkOutput($sformatf("vec%0d_led_n", idx), ledN, v.expLedN);
    busIf.we = 1'b0;
  endtask

  task automatic resetDut();
    @(negedge clk);
    reset        = 1'b1;
    busIf.we     = 1'b0;
    busIf.addr   = 2'd0;
    busIf.byteen = 4'h0;
    busIf.wd     = 32'd0;
    lightIn      = 32'd0;
    @(posedge clk);
    #1;
    checkOutput("reset_led_n", ledN, 32'hFFFF_FFFF);
    checkOutput("reset_ctrl", busIf.rd, 32'h0000_FF01);
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic busWrite(input logic [1:0] a, input logic [3:0] be, input logic [31:0] d);
    @(negedge clk);
    busIf.we     = 1'b1;
    busIf.addr   = a;
    busIf.byteen = be;
    busIf.wd     = d;
    @(posedge clk);
    #1;
    busIf.we = 1'b0;
  endtask

  // Watches led_n[0] and records the first falling edge, the following rising
  // edge and the next falling edge, plus how often led_n[1] was not low.
  task automatic measureWave(input int budget, output int fall1, output int rise1,
                             output int fall2, output logic found, output int led1Bad);
    logic prev;
    fall1   = -1;
    rise1   = -1;
    fall2   = -1;
    led1Bad = 0;
    @(posedge clk);
    #1;
    prev = ledN[0];
    for (int c = 1; c <= budget; c++) begin
      @(posedge clk);
      #1;
      if (ledN[1] !== 1'b0) led1Bad++;
      if (prev && !ledN[0]) begin
        if (fall1 < 0) fall1 = c;
        else if (rise1 >= 0 && fall2 < 0) fall2 = c;
      end
      if (!prev && ledN[0] && fall1 >= 0 && rise1 < 0) rise1 = c;
      prev = ledN[0];
      if (fall2 >= 0) break;
    end
    found = (fall2 >= 0);
  endtask

  initial begin
    int   f1, r1, f2, bad, lows, highs;
    logic found;

    checks       = 0;
    errors       = 0;
    reset        = 1'b0;
    lightIn      = 32'd0;
    busIf.we     = 1'b0;
    busIf.addr   = 2'd0;
    busIf.byteen = 4'h0;
    busIf.wd     = 32'd0;

    vecs[0]  = '{1'b0, 2'd0, 4'h0, 32'h0000_0000, 32'h0000_A5A5, 32'h0000_FF01, 32'hFFFF_5A5A};
    vecs[1]  = '{1'b0, 2'd1, 4'h0, 32'h0000_0000, 32'h0000_A5A5, 32'h0000_0000, 32'hFFFF_5A5A};
    vecs[2]  = '{1'b0, 2'd2, 4'h0, 32'h0000_0000, 32'h0000_A5A5, 32'h0000_0000, 32'hFFFF_5A5A};
    vecs[3]  = '{1'b0, 2'd3, 4'h0, 32'h0000_0000, 32'h0000_A5A5, 32'h0000_0000, 32'hFFFF_5A5A};
    vecs[4]  = '{1'b1, 2'd0, 4'b0010, 32'hFFFF_40FF, 32'h0000_0001, 32'h0000_4001, 32'hFFFF_FFFE};
    vecs[5]  = '{1'b1, 2'd3, 4'hF, 32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0000, 32'hFFFF_FFFF};
    vecs[6]  = '{1'b0, 2'd0, 4'h0, 32'h0000_0000, 32'h0000_0000, 32'h0000_4001, 32'hFFFF_FFFF};
    vecs[7]  = '{1'b1, 2'd1, 4'hF, 32'h1234_5678, 32'h0000_0000, 32'h0000_5678, 32'hFFFF_FFFF};
    vecs[8]  = '{1'b1, 2'd1, 4'b0010, 32'h0000_AB00, 32'h0000_0000, 32'h0000_AB78, 32'hFFFF_FFFF};
    vecs[9]  = '{1'b1, 2'd2, 4'b0101, 32'hAABB_CCDD, 32'h0000_0000, 32'h00BB_00DD, 32'hFFFF_FFFF};
    vecs[10] = '{1'b1, 2'd2, 4'b1010, 32'h1122_3344, 32'h0000_0000, 32'h11BB_33DD, 32'hFFFF_FFFF};
    vecs[11] = '{1'b1, 2'd0, 4'b0001, 32'hFFFF_FFFE, 32'h0000_0000, 32'h0000_4002, 32'hFFFF_FFFF};
    vecs[12] = '{1'b0, 2'd0, 4'h0, 32'h0000_0000, 32'hFFFF_FFFF, 32'h0000_4002, 32'hFFFF_FFFF};
    vecs[13] = '{1'b1, 2'd0, 4'b0011, 32'h0000_FF01, 32'hFFFF_FFFF, 32'h0000_FF01, 32'hFFFF_FFFF};

    $display("[TB] register and pass-through vectors");
    resetDut();
    for (int i = 0; i < 14; i++) begin
      applyStimulus(vecs[i], i);
    end
    @(negedge clk);
    lightIn    = 32'hFFFF_FFFF;
    busIf.addr = 2'd0;
    @(posedge clk);
    #1;
    checkOutput("reenable_all_on", ledN, 32'h0000_0000);

    $display("[TB] PWM duty 0x40, no prescaling");
    resetDut();
    lightIn = 32'h1;
    busWrite(2'd0, 4'b0010, 32'h0000_4000);
    measureWave(600, f1, r1, f2, found, bad);
    checkOutput("pwm_wave_found", {31'd0, found}, 32'd1);
    checkOutput("pwm_low_cycles", 32'(r1 - f1), 32'd64);
    checkOutput("pwm_period", 32'(f2 - f1), 32'd256);

    $display("[TB] prescale 3, duty 0x80");
    resetDut();
    lightIn = 32'h1;
    busWrite(2'd1, 4'b0011, 32'h0000_0003);
    busWrite(2'd0, 4'b0010, 32'h0000_8000);
    measureWave(2600, f1, r1, f2, found, bad);
    checkOutput("presc_wave_found", {31'd0, found}, 32'd1);
    checkOutput("presc_low_cycles", 32'(r1 - f1), 32'd512);
    checkOutput("presc_period", 32'(f2 - f1), 32'd1024);

    $display("[TB] blinking on LED 0");
    resetDut();
    lightIn = 32'h3;
    busWrite(2'd2, 4'hF, 32'h0000_0001);
    busWrite(2'd0, 4'b0001, 32'h0000_0003);
    measureWave(17000, f1, r1, f2, found, bad);
    checkOutput("blink_wave_found", {31'd0, found}, 32'd1);
    checkOutput("blink_on_cycles", 32'(r1 - f1), 32'd4096);
    checkOutput("blink_period", 32'(f2 - f1), 32'd8192);
    checkOutput("blink_led1_steady", 32'(bad), 32'd0);

    $display("[TB] reset with a write pending during BLINK_OFF");
    found = 1'b0;
    for (int c = 0; c < 5000; c++) begin
      @(posedge clk);
      #1;
      if (ledN[0] === 1'b1) begin
        found = 1'b1;
        break;
      end
    end
    checkOutput("blink_off_reached", {31'd0, found}, 32'd1);
    @(negedge clk);
    reset        = 1'b1;
    busIf.we     = 1'b1;
    busIf.addr   = 2'd0;
    busIf.byteen = 4'hF;
    busIf.wd     = 32'h0000_0000;
    @(posedge clk);
    #1;
    checkOutput("midreset_ctrl", busIf.rd, 32'h0000_FF01);
    checkOutput("midreset_led_n", ledN, 32'hFFFF_FFFF);
    busIf.addr = 2'd2;
    #1;
    checkOutput("midreset_mask", busIf.rd, 32'h0000_0000);
    busIf.addr = 2'd1;
    #1;
    checkOutput("midreset_prescale", busIf.rd, 32'h0000_0000);
    @(negedge clk);
    reset      = 1'b0;
    busIf.we   = 1'b0;
    busIf.addr = 2'd0;
    @(posedge clk);
    #1;
    checkOutput("post_reset_pass", ledN, 32'hFFFF_FFFC);
    busWrite(2'd2, 4'hF, 32'h0000_0001);
    busWrite(2'd0, 4'b0001, 32'h0000_0003);
    highs = 0;
    for (int c = 0; c < 3000; c++) begin
      @(posedge clk);
      #1;
      if (ledN[0] !== 1'b0) highs++;
    end
    checkOutput("post_reset_blink_on", 32'(highs), 32'd0);

    $display("[TB] disable and re-enable");
    resetDut();
    lightIn = 32'h1;
    busWrite(2'd1, 4'b0011, 32'h0000_0003);
    busWrite(2'd0, 4'b0010, 32'h0000_8000);
    repeat (100) @(posedge clk);
    busWrite(2'd0, 4'b0001, 32'h0000_0000);
    @(posedge clk);
    #1;
    checkOutput("disable_led_n", ledN, 32'hFFFF_FFFF);
    repeat (20) @(posedge clk);
    #1;
    checkOutput("disable_hold_led_n", ledN, 32'hFFFF_FFFF);
    busWrite(2'd0, 4'b0001, 32'h0000_0001);
    lows = 0;
    for (int c = 0; c < 2000; c++) begin
      @(posedge clk);
      #1;
      if (ledN[0] === 1'b0) lows++;
      else break;
    end
    checkOutput("reenable_first_low_run", 32'(lows), 32'd509);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
